// File: rtl/data_mem_uart_loader.sv
// UART 8N1 receiver that packs 3-byte groups into DATA_WIDTH words and writes
// them to data memory, holding the CPU in reset until MEM_SIZE words are loaded.
module data_mem_uart_loader #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256,
  parameter int CLKS_PER_BIT  = 434
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     rx_active,
  output logic                     frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);

  // One extra bit so MEM_SIZE == 2**ADDRESS_WIDTH is still countable.
  localparam int WW = ADDRESS_WIDTH + 1;
  localparam logic [WW-1:0] WORDS_ALL = WW'(MEM_SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_meta;
  logic          rx_sync;
  logic [1:0]    rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [1:0]    byte_idx;
  logic [3:0]    byte0_nib;
  logic [7:0]    byte1;
  logic [WW-1:0] word_cnt;

  assign rx_active = (rx_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_state    <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      byte_idx    <= '0;
      byte0_nib   <= '0;
      byte1       <= '0;
      word_cnt    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      mem_we  <= 1'b0;

      // The strobe cycle already sees the incremented count, so DONE lands one cycle later.
      if (mem_we && (word_cnt == WORDS_ALL)) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end

      case (rx_state)
        S_IDLE: begin
          if (!rx_sync) begin
            rx_state <= S_START;
            baud_cnt <= '0;
          end
        end

        S_START: begin
          if (baud_cnt == HALF_BIT) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              rx_state <= S_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            rx_state <= S_IDLE;
            // A bad stop bit drops the byte and realigns to the start of a word.
            if (!rx_sync) begin
              frame_error <= 1'b1;
              byte_idx    <= '0;
            end else begin
              case (byte_idx)
                2'd0: begin
                  byte0_nib <= shift_reg[3:0];
                  byte_idx  <= 2'd1;
                end
                2'd1: begin
                  byte1    <= shift_reg;
                  byte_idx <= 2'd2;
                end
                default: begin
                  byte_idx <= 2'd0;
                  if (!done) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_cnt[ADDRESS_WIDTH-1:0];
                    mem_wdata <= DATA_WIDTH'({byte0_nib, byte1, shift_reg});
                    word_cnt  <= word_cnt + 1'b1;
                  end
                end
              endcase
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_uart_loader.sv
// Randomized bench for data_mem_uart_loader: serial frames are driven bit by bit
// and the observed memory writes are compared with a byte-level packing model.
module tb_data_mem_uart_loader;

  localparam int CPB = 8;
  localparam int MEM = 4;
  localparam int AW  = 8;
  localparam int DW  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          rx_active;
  logic          frame_error;

  data_mem_uart_loader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_SIZE(MEM), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .rx_active(rx_active),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] act_addr[$];
  logic [DW-1:0] act_data[$];
  int            act_cyc[$];

  // Every cycle with the write strobe high is logged as a separate write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
      act_cyc.push_back(cyc);
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            frame_start;
  int            exp_idx;
  int            exp_words;
  logic [3:0]    exp_nib;
  logic [7:0]    exp_b1;
  bit            exp_ferr;
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clearModel();
    exp_idx   = 0;
    exp_words = 0;
    exp_nib   = '0;
    exp_b1    = '0;
    exp_ferr  = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    act_addr.delete();
    act_data.delete();
    act_cyc.delete();
  endtask

  // Byte-level packing rules: three good bytes make a word, a bad stop bit restarts the word.
  task automatic modelByte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      exp_ferr = 1'b1;
      exp_idx  = 0;
    end else if (exp_idx == 0) begin
      exp_nib = b[3:0];
      exp_idx = 1;
    end else if (exp_idx == 1) begin
      exp_b1  = b;
      exp_idx = 2;
    end else begin
      exp_idx = 0;
      if (exp_words < MEM) begin
        exp_addr.push_back(AW'(exp_words));
        exp_data.push_back({exp_nib, exp_b1, b});
        exp_words++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
    frame_start = cyc;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    modelByte(b, stop_ok);
  endtask

  task automatic sendWord(input logic [DW-1:0] w);
    logic [7:0] b0;
    b0 = {4'($urandom), w[19:16]};
    applyStimulus(b0, 1'b1);
    applyStimulus(w[15:8], 1'b1);
    applyStimulus(w[7:0], 1'b1);
  endtask

  task automatic doReset();
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clearModel();
    @(negedge clk);
  endtask

  task automatic checkWrites(input string tag);
    int n;
    checkOutput({tag, "_write_count"}, act_addr.size(), exp_addr.size());
    n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_addr"}, act_addr[i], exp_addr[i]);
      checkOutput({tag, "_wdata"}, act_data[i], exp_data[i]);
    end
    act_addr.delete();
    act_data.delete();
    act_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_done"}, done, exp_words >= MEM);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, exp_words < MEM);
    checkOutput({tag, "_frame_error"}, frame_error, exp_ferr);
    checkOutput({tag, "_rx_active"}, rx_active, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_we"}, mem_we, 1'b0);
    checkOutput({tag, "_mem_addr"}, mem_addr, '0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, '0);
    checkOutput({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_rx_active"}, rx_active, 1'b0);
    checkOutput({tag, "_frame_error"}, frame_error, 1'b0);
  endtask

  initial begin
    int bad;
    int lat;
    bit lat_ok;
    logic [DW-1:0] w;
    rst     = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    doReset();

    // Idle line after reset: the CPU stays held and nothing is written.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cpu_hold !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0 || frame_error !== 1'b0) bad++;
    end
    checkOutput("t1_bad_idle_cycles", bad, 0);
    checkResetValues("t1");

    // One word, including the strobe position relative to the last frame.
    applyStimulus(8'hF1, 1'b1);
    applyStimulus(8'h23, 1'b1);
    applyStimulus(8'h45, 1'b1);
    lat    = (act_cyc.size() > 0) ? act_cyc[0] - frame_start : -1;
    lat_ok = (act_cyc.size() == 1) && (lat >= 9 * CPB + 1) && (lat <= 10 * CPB + 10);
    checkOutput("t2_strobe_timing_ok", lat_ok, 1'b1);
    checkOutput("t2_model_word", exp_data.size() > 0 ? exp_data[0] : '0, 20'h12345);
    checkWrites("t2");

    // Fill the memory, then confirm extra bytes are framed but ignored.
    doReset();
    sendWord(20'h00001);
    sendWord(20'h00002);
    sendWord(20'h00003);
    sendWord(20'hABCDE);
    checkWrites("t3");
    checkStatus("t3");
    applyStimulus(8'($urandom), 1'b1);
    applyStimulus(8'($urandom), 1'b1);
    applyStimulus(8'($urandom), 1'b1);
    checkWrites("t3_after_done");
    checkStatus("t3_after_done");

    // A short low pulse must not start a byte or disturb word alignment.
    doReset();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checkWrites("t4_glitch");
    checkStatus("t4_glitch");
    w = DW'($urandom);
    sendWord(w);
    checkWrites("t4_after_glitch");

    // Bad stop bit realigns the word and leaves a sticky error.
    doReset();
    applyStimulus(8'h12, 1'b0);
    applyStimulus(8'h0A, 1'b1);
    applyStimulus(8'hBC, 1'b1);
    applyStimulus(8'hDE, 1'b1);
    checkWrites("t5");
    checkStatus("t5");

    // Reset in the middle of a frame discards the partial word.
    doReset();
    sendWord(DW'($urandom));
    checkWrites("t6_pre");
    applyStimulus(8'($urandom), 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'($urandom);
      repeat (CPB) @(negedge clk);
    end
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearModel();
    @(negedge clk);
    checkResetValues("t6");
    sendWord(DW'($urandom));
    checkWrites("t6_fresh");

    // Random byte stream with occasional bad stop bits.
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(8'($urandom), $urandom_range(0, 4) != 0);
    end
    checkWrites("t7_random");
    checkStatus("t7_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
